// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable registered-read or fall-through output,
// occupancy count, almost-full/almost-empty thresholds and sticky error status.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int FIFO_SIZE = 16,
  parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = FIFO_SIZE - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic               clk,
  input  logic               res,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow,
  output logic [PTR_WIDTH:0] count,
  input  logic               clr_err,
  output logic [1:0]         err_sticky
);

  localparam logic [PTR_WIDTH:0]   LP_FULL    = FIFO_SIZE[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0]   LP_AF      = AF_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0]   LP_AE      = AE_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH-1:0] LP_PTR_ONE = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   LP_CNT_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]     r_mem [FIFO_SIZE];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [PTR_WIDTH:0]   r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [1:0]           r_err_sticky;

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_ovf;
  logic                 w_udf;
  logic [PTR_WIDTH:0]   w_count_nxt;

  // Accepts look only at the registered flags, so a simultaneous read never
  // frees space for a write at full, nor a write feeds a read at empty.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_ovf    = wr_en & r_full;
  assign w_udf    = rd_en & r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
      2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_err_sticky   <= 2'b00;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == LP_FULL);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= LP_AF);
      r_almost_empty <= (w_count_nxt <= LP_AE);
      r_overflow     <= w_ovf;
      r_underflow    <= w_udf;
      // A new error in the same cycle as clr_err survives the clear.
      r_err_sticky   <= (clr_err ? 2'b00 : r_err_sticky) | {w_udf, w_ovf};
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (!res) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[r_rd_ptr];
        end
      end
      assign rdata = r_rdata;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign count        = r_count;
  assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives one registered-read and one fall-through FIFO with identical stimulus
// and compares both against a queue-based reference model every cycle.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       res;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] rdata0, rdata1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;
  logic [1:0] err0, err1;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_rdata0 = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [1:0] m_err = 2'b00;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(8), .FIFO_SIZE(16), .FWFT(0)) u_dut0 (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(udf0), .count(count0),
    .clr_err(clr_err), .err_sticky(err0)
  );

  sync_fifo_flex #(.WIDTH(8), .FIFO_SIZE(16), .FWFT(1)) u_dut1 (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(udf1), .count(count1),
    .clr_err(clr_err), .err_sticky(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the FIFO is just a queue; occupancy is its size.
  task automatic model_edge(input logic w, input logic [7:0] d, input logic r,
                            input logic c, input logic rs);
    bit was_full, was_empty;
    if (!rs) begin
      m_q.delete();
      m_rdata0 = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_err = 2'b00;
    end else begin
      was_full  = (m_q.size() == 16);
      was_empty = (m_q.size() == 0);
      if (r && !was_empty) m_rdata0 = m_q.pop_front();
      if (w && !was_full) m_q.push_back(d);
      m_ovf = w && was_full;
      m_udf = r && was_empty;
      m_err = (c ? 2'b00 : m_err) | {m_udf, m_ovf};
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] exp_fwft;
    n = m_q.size();
    exp_fwft = (n == 0) ? 8'h00 : m_q[0];
    chk("count0", 32'(count0), 32'(n));
    chk("count1", 32'(count1), 32'(n));
    chk("full0", 32'(full0), 32'(n == 16));
    chk("full1", 32'(full1), 32'(n == 16));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("almost_full0", 32'(af0), 32'(n >= 14));
    chk("almost_full1", 32'(af1), 32'(n >= 14));
    chk("almost_empty0", 32'(ae0), 32'(n <= 2));
    chk("almost_empty1", 32'(ae1), 32'(n <= 2));
    chk("overflow0", 32'(ovf0), 32'(m_ovf));
    chk("overflow1", 32'(ovf1), 32'(m_ovf));
    chk("underflow0", 32'(udf0), 32'(m_udf));
    chk("underflow1", 32'(udf1), 32'(m_udf));
    chk("err_sticky0", 32'(err0), 32'(m_err));
    chk("err_sticky1", 32'(err1), 32'(m_err));
    chk("rdata_reg", 32'(rdata0), 32'(m_rdata0));
    chk("rdata_fwft", 32'(rdata1), 32'(exp_fwft));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    wr_en = w; wdata = d; rd_en = r; clr_err = c; res = rs;
    model_edge(w, d, r, c, rs);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int wp, rp;
    logic [7:0] d;
    wr_en = 1'b0; wdata = 8'h00; rd_en = 1'b0; clr_err = 1'b0; res = 1'b0;
    #2;
    do_reset();
    do_reset();

    // Fill to full with 0x01..0x10.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_count", 32'(count0), 32'd16);

    // 17 writes then 16 reads.
    do_reset();
    for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    chk("ovf_pulse", 32'(ovf0), 32'd1);
    chk("ovf_sticky", 32'(err0), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("drain_order", 32'(rdata0), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", 32'(empty0), 32'd1);

    // Fill then over-read, then clear sticky.
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("udf_pulse", 32'(udf0), 32'd1);
    chk("udf_hold_rdata", 32'(rdata0), 32'h10);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_err", 32'(err0), 32'd0);

    // Steady state with simultaneous traffic across pointer wraps.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 5; i < 45; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b1);
    chk("steady_count", 32'(count0), 32'd5);

    // Simultaneous requests at the empty and full boundaries.
    do_reset();
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Fall-through visibility.
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("fwft_show", 32'(rdata1), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("fwft_pop_zero", 32'(rdata1), 32'h00);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("fwft_head", 32'(rdata1), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("fwft_next", 32'(rdata1), 32'h7E);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of operation drops the concurrent write.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("midreset_count", 32'(count0), 32'd0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("midreset_data", 32'(rdata0), 32'h55);

    // Random traffic with shifting write/read bias to visit full and empty.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wp = $urandom_range(20, 90);
        rp = 110 - wp;
      end
      d = 8'($urandom);
      step(($urandom_range(0, 99) < wp), d, ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
